// File: rtl/ce_result_packer_if.sv
// Engine-side result stream and writer-side packed-word stream of one
// compute-engine tile result packer, bundled as a single interface.
interface ce_result_packer_if #(
   parameter int LANES = 16
);
   localparam int LW = $clog2(LANES + 1);

   // engine side
   logic                 i_tile_en;
   logic                 i_tile_done;
   logic [15:0]          i_result_data;
   logic                 i_result_valid;
   logic                 o_result_full;
   logic                 o_result_afull;
   logic [15:0]          o_result_count;
   logic                 o_overflow;

   // result-writer side
   logic [LANES*16-1:0]  o_word_data;
   logic [LW-1:0]        o_word_lanes;
   logic                 o_word_last;
   logic                 o_word_valid;
   logic                 i_word_ready;

   // environment view: drives engine results and writer ready
   modport master (
      output i_tile_en, i_tile_done, i_result_data, i_result_valid, i_word_ready,
      input  o_result_full, o_result_afull, o_result_count, o_overflow,
             o_word_data, o_word_lanes, o_word_last, o_word_valid
   );

   // packer view
   modport slave (
      input  i_tile_en, i_tile_done, i_result_data, i_result_valid, i_word_ready,
      output o_result_full, o_result_afull, o_result_count, o_overflow,
             o_word_data, o_word_lanes, o_word_last, o_word_valid
   );
endinterface

// File: rtl/ce_result_packer.sv
// Packs the serial FP16 result stream of a compute-engine tile into
// LANES-wide words, buffers them in a show-ahead FIFO and flushes the
// partial word tagged LAST a fixed delay after the engine signals tile done.
module ce_result_packer #(
   parameter int LANES        = 16,
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 2,
   parameter int FLUSH_DELAY  = 3
) (
   input logic          i_clk,
   input logic          i_reset_n,
   ce_result_packer_if.slave bus
);
   localparam int WORD_W = LANES * 16;
   localparam int LW     = $clog2(LANES + 1);
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;
   localparam int ENT_W  = WORD_W + LW + 1;
   localparam int DCW    = (FLUSH_DELAY < 2) ? 1 : $clog2(FLUSH_DELAY);

   typedef enum logic [1:0] {S_RUN, S_FLUSH_WAIT, S_FLUSH} state_t;

   state_t            state, state_nxt;
   logic [DCW-1:0]    dly_cnt;
   logic [LW-1:0]     lane_cnt;
   logic [LW-1:0]     wr_lane;
   logic [WORD_W-1:0] lane_q;
   logic [WORD_W-1:0] full_word;
   logic [WORD_W-1:0] flush_word;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [ENT_W-1:0]  head;
   logic [ENT_W-1:0]  push_ent;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [15:0]       result_count;
   logic              overflow;
   logic              acc, pop, full, room, flush_go, word_done, push, ovf_set;

   // i_tile_en wins over every other engine input in the same cycle
   assign acc       = bus.i_result_valid && !bus.i_tile_en;
   assign pop       = (count != '0) && bus.i_word_ready;
   assign full      = (count == CW'(DEPTH));
   assign room      = !full || pop;
   assign flush_go  = (state == S_FLUSH) && room && !bus.i_tile_en;
   // a result arriving in the flush cycle starts the next word, so it never completes this one
   assign word_done = acc && !flush_go && (lane_cnt == LW'(LANES - 1));
   assign push      = flush_go || (word_done && room);
   assign ovf_set   = word_done && !room;
   assign wr_lane   = flush_go ? '0 : lane_cnt;
   assign push_ent  = flush_go ? {1'b1, lane_cnt, flush_word}
                               : {1'b0, LW'(LANES), full_word};

   // completed word includes the lane landing this cycle; flush word zeroes unfilled lanes
   always_comb begin
      full_word  = lane_q;
      flush_word = '0;
      for (int k = 0; k < LANES; k++) begin
         if (LW'(k) == lane_cnt) full_word[16*k +: 16] = bus.i_result_data;
         if (LW'(k) < lane_cnt)  flush_word[16*k +: 16] = lane_q[16*k +: 16];
      end
   end

   // lane data holding register; stale lanes are masked by lane_cnt, so no reset
   always_ff @(posedge i_clk) begin
      if (acc) lane_q[16*wr_lane +: 16] <= bus.i_result_data;
   end

   // packer control: lane position, accepted-result count, sticky overflow
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         lane_cnt     <= '0;
         result_count <= '0;
         overflow     <= 1'b0;
      end else if (bus.i_tile_en) begin
         lane_cnt     <= '0;
         result_count <= '0;
         overflow     <= 1'b0;
      end else begin
         if (acc)     result_count <= result_count + 16'd1;
         if (ovf_set) overflow <= 1'b1;
         if (flush_go)       lane_cnt <= acc ? LW'(1) : '0;
         else if (word_done) lane_cnt <= '0;
         else if (acc)       lane_cnt <= lane_cnt + LW'(1);
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= S_RUN;
      else            state <= state_nxt;
   end

   // FSM next state; the done cycle counts as the first of FLUSH_DELAY wait cycles
   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN:        if (bus.i_tile_done)
                          state_nxt = (FLUSH_DELAY <= 1) ? S_FLUSH : S_FLUSH_WAIT;
         S_FLUSH_WAIT: if (dly_cnt <= DCW'(1)) state_nxt = S_FLUSH;
         S_FLUSH:      if (room) state_nxt = S_RUN;
         default:      state_nxt = S_RUN;
      endcase
      if (bus.i_tile_en) state_nxt = S_RUN;
   end

   // flush delay counter: wait cycles remaining before the flush cycle
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         dly_cnt <= '0;
      else if (bus.i_tile_en)
         dly_cnt <= '0;
      else if ((state == S_RUN) && bus.i_tile_done)
         dly_cnt <= DCW'(FLUSH_DELAY - 1);
      else if ((state == S_FLUSH_WAIT) && (dly_cnt != '0))
         dly_cnt <= dly_cnt - DCW'(1);
   end

   // FIFO storage; push with a same-cycle pop is honoured even when full
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= push_ent;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
      end
   end

   // head fields read as zero while empty so a reset FIFO shows all-zero outputs
   assign head               = mem[rd_ptr];
   assign bus.o_word_valid   = (count != '0);
   assign bus.o_word_data    = bus.o_word_valid ? head[WORD_W-1:0] : '0;
   assign bus.o_word_lanes   = bus.o_word_valid ? head[WORD_W +: LW] : '0;
   assign bus.o_word_last    = bus.o_word_valid && head[ENT_W-1];
   assign bus.o_result_full  = full;
   assign bus.o_result_afull = (count >= CW'(DEPTH - AFULL_MARGIN));
   assign bus.o_result_count = result_count;
   assign bus.o_overflow     = overflow;
endmodule
